// File: rtl/usr_lane_shifter_if.sv
// Command and data bundle for the lane shifter: command handshake, parallel
// and serial lane data, and status outputs.
interface usr_lane_shifter_if #(
  parameter int LANE_W = 16,
  parameter int LANES  = 32,
  parameter int CNT_W  = $clog2(LANES + 1)
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [2:0]              cmd_op;
  logic [CNT_W-1:0]        cmd_cnt;
  logic [LANE_W*LANES-1:0] p_in;
  logic [LANE_W-1:0]       s_left_in;
  logic [LANE_W-1:0]       s_right_in;
  logic [LANE_W*LANES-1:0] p_out;
  logic [LANE_W-1:0]       s_left_out;
  logic [LANE_W-1:0]       s_right_out;
  logic                    busy;
  logic                    done;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, p_in, s_left_in, s_right_in,
    input  cmd_ready, p_out, s_left_out, s_right_out, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, p_in, s_left_in, s_right_in,
    output cmd_ready, p_out, s_left_out, s_right_out, busy, done
  );
endinterface

// File: rtl/usr_lane_shifter.sv
// Command-driven lane shift register: LOAD/CLEAR complete at the accept edge,
// shifts and rotates step one lane per cycle in SHIFT.
//
// state   | meaning
// S_IDLE  | ready for a command; single-cycle ops execute here
// S_SHIFT | stepping one lane per edge until rem_q reaches zero
module usr_lane_shifter #(
  parameter int LANE_W = 16,
  parameter int LANES  = 32,
  parameter int CNT_W  = $clog2(LANES + 1)
) (
  input logic               clk,
  input logic               rst,
  usr_lane_shifter_if.slave bus
);
  localparam int W = LANE_W * LANES;
  localparam logic [CNT_W-1:0] LANES_C = CNT_W'(LANES);
  localparam logic [2:0] OP_SHL   = 3'd1;
  localparam logic [2:0] OP_SHR   = 3'd2;
  localparam logic [2:0] OP_ROL   = 3'd3;
  localparam logic [2:0] OP_ROR   = 3'd4;
  localparam logic [2:0] OP_LOAD  = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [W-1:0]     data_q, data_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] eff_cnt;
  logic             accept;
  logic             shift_cmd;

  assign eff_cnt   = (bus.cmd_cnt > LANES_C) ? LANES_C : bus.cmd_cnt;
  assign accept    = bus.cmd_valid && (state_q == S_IDLE);
  // Zero-count shifts are handled like NOP so they never enter SHIFT.
  assign shift_cmd = (bus.cmd_op >= OP_SHL) && (bus.cmd_op <= OP_ROR) && (eff_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && shift_cmd) state_d = S_SHIFT;
      S_SHIFT: if (rem_q == CNT_W'(1)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      op_q   <= '0;
      rem_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      op_q   <= op_d;
      rem_q  <= rem_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    data_d = data_q;
    op_d   = op_q;
    rem_d  = rem_q;
    done_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (accept) begin
        if (shift_cmd) begin
          op_d  = bus.cmd_op;
          rem_d = eff_cnt;
        end else begin
          done_d = 1'b1;
          if (bus.cmd_op == OP_LOAD)  data_d = bus.p_in;
          if (bus.cmd_op == OP_CLEAR) data_d = '0;
        end
      end
    end else begin
      rem_d  = rem_q - CNT_W'(1);
      done_d = (rem_q == CNT_W'(1));
      case (op_q)
        OP_SHL:  data_d = {data_q[W-LANE_W-1:0], bus.s_left_in};
        OP_SHR:  data_d = {bus.s_right_in, data_q[W-1:LANE_W]};
        OP_ROL:  data_d = {data_q[W-LANE_W-1:0], data_q[W-1:W-LANE_W]};
        OP_ROR:  data_d = {data_q[LANE_W-1:0], data_q[W-1:LANE_W]};
        default: data_d = data_q;
      endcase
    end
  end

  always_comb begin
    bus.cmd_ready = (state_q == S_IDLE);
    bus.busy      = (state_q == S_SHIFT);
  end

  assign bus.done        = done_q;
  assign bus.p_out       = data_q;
  assign bus.s_left_out  = data_q[W-1:W-LANE_W];
  assign bus.s_right_out = data_q[LANE_W-1:0];
endmodule

// File: tb/tb_usr_lane_shifter.sv
// Bench for usr_lane_shifter: vector table, hand-written corner sequences and
// random commands against a queue-based lane model; plus a small 8x4 instance.
module tb_usr_lane_shifter;
  localparam int LW  = 16;
  localparam int LN  = 32;
  localparam int CW  = $clog2(LN + 1);
  localparam int W   = LW * LN;
  localparam int SLW = 8;
  localparam int SLN = 4;
  localparam int SCW = $clog2(SLN + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usr_lane_shifter_if #(.LANE_W(LW), .LANES(LN), .CNT_W(CW)) bus ();
  usr_lane_shifter #(.LANE_W(LW), .LANES(LN), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus));

  usr_lane_shifter_if #(.LANE_W(SLW), .LANES(SLN), .CNT_W(SCW)) sbus ();
  usr_lane_shifter #(.LANE_W(SLW), .LANES(SLN), .CNT_W(SCW)) sdut (
    .clk(clk), .rst(rst), .bus(sbus));

  int n_chk  = 0;
  int n_pass = 0;
  logic [LW-1:0] mq[$];

  typedef struct {
    logic [2:0]    op;
    int            cnt;
    logic [LW-1:0] sl;
    logic [LW-1:0] sr;
    int            busy;
    logic [LW-1:0] l0;
    logic [LW-1:0] l1;
    logic [LW-1:0] ltop;
  } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] mpack();
    logic [W-1:0] p;
    p = '0;
    for (int i = 0; i < LN; i++) p[i*LW +: LW] = mq[i];
    return p;
  endfunction

  function automatic logic [W-1:0] ramp();
    logic [W-1:0] p;
    for (int i = 0; i < LN; i++) p[i*LW +: LW] = LW'(i);
    return p;
  endfunction

  function automatic logic [LW-1:0] lane(input logic [W-1:0] p, input int i);
    return p[i*LW +: LW];
  endfunction

  // Issue one command, follow it to completion while keeping the model in step.
  task automatic issue(input logic [2:0] op, input int cnt, input logic [W-1:0] pin,
                       input logic [LW-1:0] sl_fix, input logic [LW-1:0] sr_fix,
                       input bit rnd, output int nbusy);
    int k, t;
    logic [LW-1:0] sl, sr, v;
    t = 0;
    while (!bus.cmd_ready && t < 100) begin tick(); t++; end
    check("ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_cnt   = CW'(cnt);
    bus.p_in      = pin;
    tick();
    bus.cmd_valid = 1'b0;
    bus.p_in      = ~pin;
    if (op == 3'd5) for (int i = 0; i < LN; i++) mq[i] = lane(pin, i);
    if (op == 3'd6) for (int i = 0; i < LN; i++) mq[i] = '0;
    k = (op >= 3'd1 && op <= 3'd4) ? ((cnt > LN) ? LN : cnt) : 0;
    nbusy = 0;
    for (int j = 0; j < k; j++) begin
      if (bus.busy) nbusy++;
      sl = rnd ? LW'($urandom) : sl_fix;
      sr = rnd ? LW'($urandom) : sr_fix;
      bus.s_left_in  = sl;
      bus.s_right_in = sr;
      check("s_left_out", bus.s_left_out, mq[LN-1]);
      check("s_right_out", bus.s_right_out, mq[0]);
      tick();
      case (op)
        3'd1: begin mq.push_front(sl); v = mq.pop_back(); end
        3'd2: begin v = mq.pop_front(); mq.push_back(sr); end
        3'd3: begin v = mq.pop_back(); mq.push_front(v); end
        default: begin v = mq.pop_front(); mq.push_back(v); end
      endcase
    end
    check("busy_cycles", nbusy, k);
    check("busy_after", bus.busy, 0);
    check("done_pulse", bus.done, 1);
    check("ready_in_done", bus.cmd_ready, 1);
    check("p_out", bus.p_out, mpack());
    tick();
    check("done_single", bus.done, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    logic [W-1:0] pin;
    logic [2:0] op;
    int cnt;

    tbl[0] = '{3'd5, 0,  16'h0,    16'h0,    0,  16'd0,    16'd1,    16'd31};
    tbl[1] = '{3'd1, 2,  16'h1111, 16'h0,    2,  16'h1111, 16'h1111, 16'd29};
    tbl[2] = '{3'd2, 1,  16'h0,    16'hBEEF, 1,  16'h1111, 16'd0,    16'hBEEF};
    tbl[3] = '{3'd3, 1,  16'h0,    16'h0,    1,  16'hBEEF, 16'h1111, 16'd29};
    tbl[4] = '{3'd4, 40, 16'h0,    16'h0,    32, 16'hBEEF, 16'h1111, 16'd29};
    tbl[5] = '{3'd6, 0,  16'h0,    16'h0,    0,  16'd0,    16'd0,    16'd0};
    tbl[6] = '{3'd0, 5,  16'h0,    16'h0,    0,  16'd0,    16'd0,    16'd0};

    rst = 1'b1;
    bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_cnt = 0; bus.p_in = '0;
    bus.s_left_in = 0; bus.s_right_in = 0;
    sbus.cmd_valid = 0; sbus.cmd_op = 0; sbus.cmd_cnt = 0; sbus.p_in = '0;
    sbus.s_left_in = 0; sbus.s_right_in = 0;
    for (int i = 0; i < LN; i++) mq.push_back('0);
    repeat (2) tick();
    rst = 1'b0;
    check("rst_p_out", bus.p_out, 0);
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_small_p_out", sbus.p_out, 0);

    for (int i = 0; i < 7; i++) begin
      pin = (tbl[i].op == 3'd5) ? ramp() : '0;
      issue(tbl[i].op, tbl[i].cnt, pin, tbl[i].sl, tbl[i].sr, 0, nb);
      check($sformatf("tbl%0d_busy", i), nb, tbl[i].busy);
      check($sformatf("tbl%0d_lane0", i), lane(bus.p_out, 0), tbl[i].l0);
      check($sformatf("tbl%0d_lane1", i), lane(bus.p_out, 1), tbl[i].l1);
      check($sformatf("tbl%0d_lane_top", i), lane(bus.p_out, LN-1), tbl[i].ltop);
    end

    // SHL 3 with a distinct serial lane on each step
    issue(3'd5, 0, ramp(), 0, 0, 0, nb);
    bus.cmd_valid = 1; bus.cmd_op = 3'd1; bus.cmd_cnt = CW'(3);
    tick();
    bus.cmd_valid = 0;
    nb = 0;
    for (int j = 0; j < 3; j++) begin
      if (bus.busy) nb++;
      bus.s_left_in = LW'(16'hA000 + j);
      tick();
    end
    check("shl3_busy_cycles", nb, 3);
    check("shl3_done", bus.done, 1);
    check("shl3_lane0", lane(bus.p_out, 0), 16'hA002);
    check("shl3_lane1", lane(bus.p_out, 1), 16'hA001);
    check("shl3_lane2", lane(bus.p_out, 2), 16'hA000);
    check("shl3_lane3", lane(bus.p_out, 3), 16'd0);
    check("shl3_lane31", lane(bus.p_out, 31), 16'd28);
    tick();

    // ROR 32: s_right_out walks the ramp, contents wrap back to the original
    issue(3'd5, 0, ramp(), 0, 0, 0, nb);
    bus.cmd_valid = 1; bus.cmd_op = 3'd4; bus.cmd_cnt = CW'(32);
    tick();
    bus.cmd_valid = 0;
    for (int j = 0; j < LN; j++) begin
      check($sformatf("ror32_s_right_out%0d", j), bus.s_right_out, LW'(j));
      tick();
    end
    check("ror32_p_out", bus.p_out, ramp());
    check("ror32_done", bus.done, 1);
    tick();

    // SHR 1 with a command held pending during busy
    issue(3'd5, 0, ramp(), 0, 0, 0, nb);
    bus.s_right_in = 16'hBEEF;
    bus.cmd_valid = 1; bus.cmd_op = 3'd2; bus.cmd_cnt = CW'(1);
    tick();
    bus.cmd_op = 3'd6;
    check("shr1_ready_low", bus.cmd_ready, 0);
    check("shr1_busy", bus.busy, 1);
    tick();
    check("shr1_lane31", lane(bus.p_out, 31), 16'hBEEF);
    check("shr1_lane0", lane(bus.p_out, 0), 16'd1);
    check("shr1_done", bus.done, 1);
    check("shr1_ready_in_done", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 0;
    check("held_clear_p_out", bus.p_out, 0);
    check("held_clear_done", bus.done, 1);
    tick();
    check("held_clear_done_end", bus.done, 0);

    // Reset in the middle of SHL 10
    issue(3'd5, 0, ramp(), 0, 0, 0, nb);
    bus.cmd_valid = 1; bus.cmd_op = 3'd1; bus.cmd_cnt = CW'(10);
    tick();
    bus.cmd_valid = 0;
    repeat (4) tick();
    check("midrst_busy_before", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_p_out", bus.p_out, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_ready", bus.cmd_ready, 1);
    tick();
    check("midrst_done_later", bus.done, 0);
    for (int i = 0; i < LN; i++) mq[i] = '0;

    // Zero-work commands accepted back-to-back
    issue(3'd5, 0, ramp(), 0, 0, 0, nb);
    bus.cmd_valid = 1;
    for (int j = 0; j < 3; j++) begin
      bus.cmd_op  = (j == 0) ? 3'd1 : ((j == 1) ? 3'd0 : 3'd7);
      bus.cmd_cnt = (j == 2) ? CW'(9) : CW'(0);
      tick();
      check($sformatf("zero%0d_done", j), bus.done, 1);
      check($sformatf("zero%0d_ready", j), bus.cmd_ready, 1);
      check($sformatf("zero%0d_p_out", j), bus.p_out, ramp());
    end
    bus.cmd_valid = 0;
    tick();
    check("zero_done_end", bus.done, 0);

    // Random commands against the model
    for (int i = 0; i < LN; i++) mq[i] = lane(bus.p_out, i);
    for (int n = 0; n < 40; n++) begin
      op  = 3'($urandom_range(0, 7));
      cnt = $urandom_range(0, 40);
      for (int i = 0; i < LN; i++) pin[i*LW +: LW] = LW'($urandom);
      issue(op, cnt, pin, 0, 0, 1, nb);
    end

    // Small 8x4 instance: zero-work, clamped wrap, one-lane shift
    sbus.cmd_valid = 1; sbus.cmd_op = 3'd5; sbus.p_in = 32'h04030201;
    tick();
    check("small_load", sbus.p_out, 32'h04030201);
    check("small_load_done", sbus.done, 1);
    for (int j = 0; j < 3; j++) begin
      sbus.cmd_op  = (j == 0) ? 3'd1 : ((j == 1) ? 3'd0 : 3'd7);
      sbus.cmd_cnt = (j == 2) ? SCW'(3) : SCW'(0);
      tick();
      check($sformatf("small_zero%0d_done", j), sbus.done, 1);
      check($sformatf("small_zero%0d_p_out", j), sbus.p_out, 32'h04030201);
    end
    sbus.cmd_op = 3'd3; sbus.cmd_cnt = SCW'(7);
    tick();
    sbus.cmd_valid = 0;
    nb = 0;
    for (int j = 0; j < SLN; j++) begin
      if (sbus.busy) nb++;
      tick();
    end
    check("small_rol7_busy_cycles", nb, 4);
    check("small_rol7_busy_end", sbus.busy, 0);
    check("small_rol7_done", sbus.done, 1);
    check("small_rol7_p_out", sbus.p_out, 32'h04030201);
    tick();
    sbus.cmd_valid = 1; sbus.cmd_op = 3'd1; sbus.cmd_cnt = SCW'(1); sbus.s_left_in = 8'hAA;
    tick();
    sbus.cmd_valid = 0;
    tick();
    check("small_shl1_p_out", sbus.p_out, 32'h030201AA);
    check("small_shl1_done", sbus.done, 1);
    check("small_shl1_s_left_out", sbus.s_left_out, 8'h03);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/usr_lane_shifter.md
# usr_lane_shifter

Parametrised, command-driven universal lane shift register: the successor to the fixed 32×16-bit shifter in the datapath. It holds LANES lanes of LANE_W bits and performs multi-lane shifts, rotates, parallel load and clear. Each operation is issued as a single valid/ready command and sequenced internally, one lane per cycle. It sits between the serial feature-streaming path and the parallel compute array, and signals completion with a one-cycle `done` pulse.

## Interface
Parameters:
- LANE_W, 16, bits per lane
- LANES, 32, number of lanes (≥2)
- CNT_W, $clog2(LANES+1), width of shift-count field

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (= state IDLE)
- cmd_op  in  3  0 NOP, 1 SHL, 2 SHR, 3 ROL, 4 ROR, 5 LOAD, 6 CLEAR, 7 reserved (treated as NOP)
- cmd_cnt  in  CNT_W  lanes to shift/rotate; ignored for NOP/LOAD/CLEAR
- p_in  in  LANE_W*LANES  parallel load data
- s_left_in  in  LANE_W  serial lane entering lane 0 on SHL
- s_right_in  in  LANE_W  serial lane entering lane LANES-1 on SHR
- p_out  out  LANE_W*LANES  register contents; lane i = p_out[i*LANE_W +: LANE_W]
- s_left_out  out  LANE_W  lane LANES-1 (combinational from p_out)
- s_right_out  out  LANE_W  lane 0 (combinational from p_out)
- busy  out  1  multi-cycle shift/rotate in progress (state SHIFT)
- done  out  1  one-cycle pulse: command complete

## Operation
- Reset: p_out=0, state IDLE, cmd_ready=1, busy=0, done=0, internal counter=0. Reset mid-command aborts it; no done pulse.
- Handshake: accept on a rising edge with cmd_valid&&cmd_ready. cmd_ready=0 while busy; commands presented then are held off, not dropped.
- States: IDLE, SHIFT.
  - IDLE + accepted SHL/SHR/ROL/ROR with eff_cnt>0 → SHIFT; latch op and remaining=eff_cnt. No data change at the accept edge.
  - IDLE + accepted LOAD: p_out<=p_in at the accept edge. CLEAR: p_out<=0. Stay IDLE.
  - IDLE + accepted NOP/reserved, or shift op with eff_cnt=0: no data change; stay IDLE.
  - SHIFT: each edge performs one lane step and remaining-=1. On the edge where remaining goes 1→0, return to IDLE.
- eff_cnt = min(cmd_cnt, LANES). Counts >LANES are clamped.
- One lane step:
  - SHL: lane i<=lane i-1 for i≥1; lane 0<=s_left_in, sampled that edge; old lane LANES-1 is discarded.
  - SHR: lane i<=lane i+1; lane LANES-1<=s_right_in; old lane 0 is discarded.
  - ROL: as SHL, but lane 0<=old lane LANES-1.
  - ROR: as SHR, but lane LANES-1<=old lane 0.
  - Serial inputs are ignored by rotates.
- Serial producer/consumer: s_*_in is sampled on every SHIFT edge. s_*_out reflects the lane about to leave before each edge. Consumers read it while busy.
- done: registered, high exactly one cycle after every accepted command's final update. Zero-work commands pulse as well.
- p_in is sampled only at a LOAD accept edge.

## Timing
- Accept at edge T.
  - LOAD/CLEAR/NOP/eff_cnt=0: result visible after T; done high in cycle T..T+1; cmd_ready stays 1.
  - Shift/rotate k lanes: busy high from after T through edge T+k. Steps occur at edges T+1…T+k. done high in cycle after T+k. cmd_ready returns high in that same cycle.
- Back-to-back: a new command may be accepted in the done cycle. Throughput is one single-cycle command per clock; shift commands take k+1 cycles each.
- No combinational path from cmd_* to cmd_ready.

## Test plan
- Reset/load: assert rst 2 cycles → p_out=0, cmd_ready=1, done=0. LOAD with lane i=i → p_out lane i=i next cycle, done one pulse, busy never high.
- SHL 3: after load lane i=i, drive s_left_in=0xA000,0xA001,0xA002 on successive SHIFT edges → lanes 0..2=0xA002,0xA001,0xA000, lane 3=0, lane 31=28. busy 3 cycles; done in cycle 4 after accept.
- ROR 32 (full wrap, LANES=32): result equals original. ROR 40 is clamped → same result in 32 steps. s_right_out observed in sequence 0,1,…,31.
- SHR 1 with s_right_in=0xBEEF → lane 31=0xBEEF, lane 0=old lane 1. cmd_valid held high during busy is not accepted until the done cycle, then accepted that cycle.
- Reset mid-SHL 10 after 4 steps → p_out=0 next cycle, busy=0, no done pulse.
- Zero-work: SHL cnt=0, NOP, op=7 → p_out unchanged, one done pulse each, back-to-back acceptance every cycle. Repeat with LANE_W=8, LANES=4.
